// File: rtl/program_loader.sv
// UART-side program loader: parses CMD_LOAD / length / data / checksum frames and
// writes assembled 32-bit words into instruction memory while holding loadProgram.
module program_loader #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  CMD_LOAD  = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        loadProgram,
  output logic [31:0] addressInstrucctionProgram,
  output logic [31:0] InstructionProgram,
  output logic        write_instruction,
  output logic        prog_done,
  output logic        prog_error,
  output logic [15:0] words_written,
  output logic [2:0]  dbgState
);

  // Handshake: rx_data is consumed only on cycles where rx_done=1; there is no
  // back-pressure, so every state must be able to absorb a byte on every cycle.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHECK  = 3'd5
  } state_t;

  state_t      state, nextState;
  logic [7:0]  lenLo;
  logic [15:0] wordCount;
  logic [23:0] wordBuf;
  logic [1:0]  byteIdx;
  logic [7:0]  checksum;
  logic [15:0] lenReq;
  logic [15:0] wordsNext;

  logic startFrame, takeLenLo, takeLenHi, rejectLen, takeData;
  logic bumpWords, finishOk, finishBad;

  assign lenReq            = {rx_data, lenLo};
  assign wordsNext         = words_written + 16'd1;
  assign write_instruction = (state == WRITE);
  assign dbgState          = state;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState  = state;
    startFrame = 1'b0;
    takeLenLo  = 1'b0;
    takeLenHi  = 1'b0;
    rejectLen  = 1'b0;
    takeData   = 1'b0;
    bumpWords  = 1'b0;
    finishOk   = 1'b0;
    finishBad  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done && rx_data == CMD_LOAD) begin
          startFrame = 1'b1;
          nextState  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (rx_done) begin
          takeLenLo = 1'b1;
          nextState = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_done) begin
          takeLenHi = 1'b1;
          if ({1'b0, lenReq} > 17'(MEM_WORDS)) begin
            rejectLen = 1'b1;
            nextState = IDLE;
          end else if (lenReq == 16'd0) begin
            nextState = CHECK;
          end else begin
            nextState = DATA;
          end
        end
      end
      DATA: begin
        if (rx_done) begin
          takeData = 1'b1;
          if (byteIdx == 2'd3) nextState = WRITE;
        end
      end
      WRITE: begin
        // A byte landing here is either the checksum (last word) or lane 0 of
        // the next word; byteIdx is already 0 so it cannot complete a word.
        bumpWords = 1'b1;
        if (wordsNext == wordCount) begin
          nextState = CHECK;
          if (rx_done) begin
            finishOk  = (rx_data == checksum);
            finishBad = (rx_data != checksum);
            nextState = IDLE;
          end
        end else begin
          nextState = DATA;
          takeData  = rx_done;
        end
      end
      CHECK: begin
        if (rx_done) begin
          finishOk  = (rx_data == checksum);
          finishBad = (rx_data != checksum);
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      loadProgram                <= 1'b0;
      addressInstrucctionProgram <= 32'd0;
      InstructionProgram         <= 32'd0;
      prog_done                  <= 1'b0;
      prog_error                 <= 1'b0;
      words_written              <= 16'd0;
      lenLo                      <= 8'd0;
      wordCount                  <= 16'd0;
      wordBuf                    <= 24'd0;
      byteIdx                    <= 2'd0;
      checksum                   <= 8'd0;
    end else begin
      prog_done <= 1'b0;
      if (startFrame) begin
        loadProgram   <= 1'b1;
        prog_error    <= 1'b0;
        words_written <= 16'd0;
        checksum      <= 8'd0;
        byteIdx       <= 2'd0;
      end
      if (takeLenLo) lenLo <= rx_data;
      if (takeLenHi) wordCount <= lenReq;
      if (rejectLen) begin
        prog_error  <= 1'b1;
        loadProgram <= 1'b0;
      end
      if (takeData) begin
        checksum <= checksum ^ rx_data;
        byteIdx  <= byteIdx + 2'd1;
        case (byteIdx)
          2'd0: wordBuf[7:0]   <= rx_data;
          2'd1: wordBuf[15:8]  <= rx_data;
          2'd2: wordBuf[23:16] <= rx_data;
          default: begin
            InstructionProgram         <= {rx_data, wordBuf};
            addressInstrucctionProgram <= BASE_ADDR + {14'd0, words_written, 2'b00};
          end
        endcase
      end
      if (bumpWords) words_written <= wordsNext;
      if (finishOk) begin
        prog_done   <= 1'b1;
        loadProgram <= 1'b0;
      end
      if (finishBad) begin
        prog_error  <= 1'b1;
        loadProgram <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: byte-stream frame model checked every cycle, plus
// literal expectations for the directed frames.
module tb_program_loader;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        loadProgram;
  logic [31:0] addressInstrucctionProgram;
  logic [31:0] InstructionProgram;
  logic        write_instruction;
  logic        prog_done;
  logic        prog_error;
  logic [15:0] words_written;
  logic [2:0]  dbgState;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk                        (clk),
    .rst                        (rst),
    .rx_data                    (rx_data),
    .rx_done                    (rx_done),
    .loadProgram                (loadProgram),
    .addressInstrucctionProgram (addressInstrucctionProgram),
    .InstructionProgram         (InstructionProgram),
    .write_instruction          (write_instruction),
    .prog_done                  (prog_done),
    .prog_error                 (prog_error),
    .words_written              (words_written),
    .dbgState                   (dbgState)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model over byte offsets: what each output must be after every edge.
  bit          mInFrame = 0;
  bit          mPendInc = 0;
  int          mOff = 0;
  int          mN = 0;
  int          k;
  logic [7:0]  mLo = 8'h00;
  logic [7:0]  mCks = 8'h00;
  logic [31:0] mWord = 32'h0;
  logic        expLoad = 0, expErr = 0, expDone = 0, expWe = 0;
  logic [15:0] expWords = 0;
  logic [31:0] expAddr = 0, expInstr = 0;

  always @(posedge clk) begin
    if (!rst) begin
      mInFrame = 0; mPendInc = 0;
      expLoad = 0; expErr = 0; expDone = 0; expWe = 0;
      expWords = 0; expAddr = 0; expInstr = 0;
    end else begin
      expDone = 0;
      expWe = 0;
      if (mPendInc) begin
        expWords = expWords + 16'd1;
        mPendInc = 0;
      end
      if (rx_done) begin
        if (!mInFrame) begin
          if (rx_data == 8'h01) begin
            mInFrame = 1; mOff = 0; mCks = 0;
            expErr = 0; expWords = 0; expLoad = 1;
          end
        end else begin
          if (mOff == 0) begin
            mLo = rx_data;
          end else if (mOff == 1) begin
            mN = int'({rx_data, mLo});
            if (mN > 256) begin
              expErr = 1; expLoad = 0; mInFrame = 0;
            end
          end else if (mOff < 2 + 4 * mN) begin
            k = mOff - 2;
            mCks = mCks ^ rx_data;
            mWord[8*(k%4) +: 8] = rx_data;
            if (k % 4 == 3) begin
              expWe = 1;
              expAddr = 32'(4 * (k / 4));
              expInstr = mWord;
              mPendInc = 1;
            end
          end else begin
            if (rx_data == mCks) expDone = 1;
            else expErr = 1;
            expLoad = 0;
            mInFrame = 0;
          end
          mOff++;
        end
      end
    end
  end

  // Per-cycle comparison and a log of observed writes for the literal checks.
  int          wrCnt = 0;
  int          doneCnt = 0;
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];

  always @(negedge clk) begin
    check("loadProgram", 32'(loadProgram), 32'(expLoad));
    check("prog_error", 32'(prog_error), 32'(expErr));
    check("prog_done", 32'(prog_done), 32'(expDone));
    check("write_instruction", 32'(write_instruction), 32'(expWe));
    check("words_written", 32'(words_written), 32'(expWords));
    check("address", addressInstrucctionProgram, expAddr);
    check("instruction", InstructionProgram, expInstr);
    if (write_instruction === 1'b1) begin
      wrCnt++;
      wrAddrQ.push_back(addressInstrucctionProgram);
      wrDataQ.push_back(InstructionProgram);
    end
    if (prog_done === 1'b1) doneCnt++;
  end

  function automatic byte_q_t buildFrame(input word_q_t w, input bit forceCks, input logic [7:0] forced);
    byte_q_t q;
    logic [7:0]  cks = 8'h00;
    logic [15:0] n = 16'(w.size());
    q.push_back(8'h01);
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    foreach (w[i]) begin
      for (int b = 0; b < 4; b++) begin
        q.push_back(w[i][8*b +: 8]);
        cks = cks ^ w[i][8*b +: 8];
      end
    end
    q.push_back(forceCks ? forced : cks);
    return q;
  endfunction

  task automatic sendByte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendBytes(input byte_q_t q, input int gap);
    foreach (q[i]) sendByte(q[i], gap);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    byte_q_t fr;
    word_q_t ws;
    int w0, d0;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_load", 32'(loadProgram), 32'd0);
    check("reset_words", 32'(words_written), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Two-word good frame.
    ws = '{32'h2008_0005, 32'h0000_0000};
    fr = buildFrame(ws, 1'b0, 8'h00);
    check("t1_cks_byte", 32'(fr[fr.size()-1]), 32'h2D);
    w0 = wrCnt; d0 = doneCnt;
    sendBytes(fr, 1);
    check("t1_writes", 32'(wrCnt - w0), 32'd2);
    check("t1_addr0", wrAddrQ[w0], 32'h0);
    check("t1_data0", wrDataQ[w0], 32'h2008_0005);
    check("t1_addr1", wrAddrQ[w0+1], 32'h4);
    check("t1_data1", wrDataQ[w0+1], 32'h0);
    check("t1_done", 32'(doneCnt - d0), 32'd1);
    check("t1_words", 32'(words_written), 32'd2);
    check("t1_model_words", 32'(expWords), 32'd2);
    check("t1_err", 32'(prog_error), 32'd0);

    // Same frame, bad checksum.
    fr = buildFrame(ws, 1'b1, 8'h00);
    w0 = wrCnt; d0 = doneCnt;
    sendBytes(fr, 2);
    check("t2_writes", 32'(wrCnt - w0), 32'd2);
    check("t2_done", 32'(doneCnt - d0), 32'd0);
    check("t2_err", 32'(prog_error), 32'd1);
    check("t2_load", 32'(loadProgram), 32'd0);

    // Oversize length 0x0101 is rejected immediately.
    fr = '{8'h01, 8'h01, 8'h01};
    w0 = wrCnt;
    sendBytes(fr, 0);
    check("t3_writes", 32'(wrCnt - w0), 32'd0);
    check("t3_err", 32'(prog_error), 32'd1);
    check("t3_load", 32'(loadProgram), 32'd0);

    // Garbage then an empty frame.
    fr = '{8'hFF, 8'h55, 8'h01, 8'h00, 8'h00, 8'h00};
    w0 = wrCnt; d0 = doneCnt;
    sendBytes(fr, 1);
    check("t4_writes", 32'(wrCnt - w0), 32'd0);
    check("t4_done", 32'(doneCnt - d0), 32'd1);
    check("t4_err", 32'(prog_error), 32'd0);

    // Three words with a strobe every cycle.
    ws = '{32'h1122_3344, 32'hA5A5_0F0F, 32'hDEAD_BEEF};
    fr = buildFrame(ws, 1'b0, 8'h00);
    w0 = wrCnt; d0 = doneCnt;
    sendBytes(fr, 0);
    check("t5_writes", 32'(wrCnt - w0), 32'd3);
    check("t5_addr2", wrAddrQ[w0+2], 32'h8);
    check("t5_data1", wrDataQ[w0+1], 32'hA5A5_0F0F);
    check("t5_data2", wrDataQ[w0+2], 32'hDEAD_BEEF);
    check("t5_done", 32'(doneCnt - d0), 32'd1);
    check("t5_words", 32'(words_written), 32'd3);

    // Reset after six data bytes of a two-word frame, then a fresh frame.
    ws = '{32'h0403_0201, 32'h0807_0605};
    fr = buildFrame(ws, 1'b0, 8'h00);
    w0 = wrCnt;
    for (int i = 0; i < 9; i++) sendByte(fr[i], 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t6_writes", 32'(wrCnt - w0), 32'd1);
    check("t6_rst_words", 32'(words_written), 32'd0);
    check("t6_rst_load", 32'(loadProgram), 32'd0);
    check("t6_rst_instr", InstructionProgram, 32'd0);
    repeat (2) @(negedge clk);
    ws = '{32'hCAFE_F00D};
    fr = buildFrame(ws, 1'b0, 8'h00);
    w0 = wrCnt; d0 = doneCnt;
    sendBytes(fr, 1);
    check("t6_fresh_writes", 32'(wrCnt - w0), 32'd1);
    check("t6_fresh_addr", wrAddrQ[w0], 32'h0);
    check("t6_fresh_data", wrDataQ[w0], 32'hCAFE_F00D);
    check("t6_fresh_done", 32'(doneCnt - d0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
